// File: rtl/fp32_pkg.sv
// Shared types, constants and field helpers for the FP32 add unit and its core.
package fp32_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned EXP_FIELD_W = 8;
    localparam int unsigned MAN_FIELD_W = 23;
    localparam int unsigned EXP_W       = 10;
    localparam int unsigned MAN_W       = 24;
    localparam int unsigned GRS_W       = 3;
    localparam int unsigned DP_W        = MAN_W + GRS_W;

    typedef logic signed [EXP_W-1:0] exp_t;
    typedef logic [DP_W-1:0]         dp_t;
    typedef logic [DP_W:0]           sum_t;
    typedef logic [MAN_W-1:0]        man_t;

    typedef struct packed {
        logic                   sign;
        logic [EXP_FIELD_W-1:0] exp;
        logic [MAN_FIELD_W-1:0] man;
    } fp32_t;

    localparam exp_t EXP_BIAS    = exp_t'(127);
    localparam exp_t EXP_MIN     = exp_t'(-126);
    localparam exp_t EXP_MAX     = exp_t'(127);
    localparam exp_t EXP_ONE     = exp_t'(1);
    // Beyond this exponent gap the smaller mantissa survives only as sticky.
    localparam exp_t ALIGN_FLUSH = exp_t'(DP_W - 1);

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } wrap_state_e;

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL,
        ALIGN,
        ADD_0,
        ADD_1,
        NORM_1,
        NORM_2,
        ROUND,
        PACK,
        PUT_Z
    } core_state_e;

    function automatic logic is_nan(fp32_t f);
        return (f.exp == 8'hFF) && (f.man != '0);
    endfunction

    function automatic logic is_inf(fp32_t f);
        return (f.exp == 8'hFF) && (f.man == '0);
    endfunction

    function automatic logic is_zero(fp32_t f);
        return (f.exp == 8'h00) && (f.man == '0);
    endfunction

    // Denormals sit at the minimum exponent with no hidden bit.
    function automatic exp_t unpack_exp(fp32_t f);
        return (f.exp == 8'h00) ? EXP_MIN : (exp_t'({2'b00, f.exp}) - EXP_BIAS);
    endfunction

    function automatic dp_t unpack_man(fp32_t f);
        return dp_t'({f.exp != 8'h00, f.man, 3'b000});
    endfunction

endpackage

// File: rtl/fp32_add_core.sv
// Strobe/acknowledge FP32 adder: serial align and normalise, round to nearest even.
module fp32_add_core
    import fp32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] input_a,
    input  logic [FP_W-1:0] input_b,
    input  logic            input_a_stb,
    input  logic            input_b_stb,
    output logic            input_a_ack,
    output logic            input_b_ack,
    output logic [FP_W-1:0] output_z,
    output logic            output_z_stb,
    input  logic            output_z_ack
);

    core_state_e     state_q, state_d;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic            a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    dp_t             a_m_q, a_m_d, b_m_q, b_m_d;
    exp_t            a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic            a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    sum_t            sum_q, sum_d;
    man_t            z_m_q, z_m_d;
    logic            guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;

    fp32_t fa, fb;
    exp_t  diff_ab, diff_ba;

    assign fa      = a_q;
    assign fb      = b_q;
    assign diff_ab = a_e_q - b_e_q;
    assign diff_ba = b_e_q - a_e_q;

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            z_stb_q  <= 1'b0;
            a_m_q    <= '0;
            b_m_q    <= '0;
            a_e_q    <= '0;
            b_e_q    <= '0;
            z_e_q    <= '0;
            a_s_q    <= 1'b0;
            b_s_q    <= 1'b0;
            z_s_q    <= 1'b0;
            sum_q    <= '0;
            z_m_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            z_stb_q  <= z_stb_d;
            a_m_q    <= a_m_d;
            b_m_q    <= b_m_d;
            a_e_q    <= a_e_d;
            b_e_q    <= b_e_d;
            z_e_q    <= z_e_d;
            a_s_q    <= a_s_d;
            b_s_q    <= b_s_d;
            z_s_q    <= z_s_d;
            sum_q    <= sum_d;
            z_m_q    <= z_m_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        a_ack_d  = a_ack_q;
        b_ack_d  = b_ack_q;
        z_stb_d  = z_stb_q;
        a_m_d    = a_m_q;
        b_m_d    = b_m_q;
        a_e_d    = a_e_q;
        b_e_d    = b_e_q;
        z_e_d    = z_e_q;
        a_s_d    = a_s_q;
        b_s_d    = b_s_q;
        z_s_d    = z_s_q;
        sum_d    = sum_q;
        z_m_d    = z_m_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;

        unique case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    b_ack_d = 1'b1;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_s_d   = fa.sign;
                b_s_d   = fb.sign;
                a_e_d   = unpack_exp(fa);
                b_e_d   = unpack_exp(fb);
                a_m_d   = unpack_man(fa);
                b_m_d   = unpack_man(fb);
                state_d = SPECIAL;
            end
            SPECIAL: begin
                z_stb_d = 1'b1;
                state_d = PUT_Z;
                if (is_nan(fa) || is_nan(fb)) begin
                    z_d = QNAN;
                end else if (is_inf(fa)) begin
                    z_d = (is_inf(fb) && (fa.sign != fb.sign)) ? QNAN : a_q;
                end else if (is_inf(fb)) begin
                    z_d = b_q;
                end else if (is_zero(fa) && is_zero(fb)) begin
                    z_d = {fa.sign & fb.sign, 31'h0};
                end else if (is_zero(fa)) begin
                    z_d = b_q;
                end else if (is_zero(fb)) begin
                    z_d = a_q;
                end else begin
                    z_stb_d = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                // Shift the smaller operand one place per cycle, folding lost bits into bit 0.
                if (a_e_q > b_e_q) begin
                    if (diff_ab > ALIGN_FLUSH) begin
                        b_m_d = {{(DP_W-1){1'b0}}, |b_m_q};
                        b_e_d = a_e_q;
                    end else begin
                        b_m_d = {1'b0, b_m_q[DP_W-1:2], b_m_q[1] | b_m_q[0]};
                        b_e_d = b_e_q + EXP_ONE;
                    end
                end else if (a_e_q < b_e_q) begin
                    if (diff_ba > ALIGN_FLUSH) begin
                        a_m_d = {{(DP_W-1){1'b0}}, |a_m_q};
                        a_e_d = b_e_q;
                    end else begin
                        a_m_d = {1'b0, a_m_q[DP_W-1:2], a_m_q[1] | a_m_q[0]};
                        a_e_d = a_e_q + EXP_ONE;
                    end
                end else begin
                    state_d = ADD_0;
                end
            end
            ADD_0: begin
                z_e_d = a_e_q;
                if (a_s_q == b_s_q) begin
                    sum_d = sum_t'(a_m_q) + sum_t'(b_m_q);
                    z_s_d = a_s_q;
                end else if (a_m_q >= b_m_q) begin
                    sum_d = sum_t'(a_m_q - b_m_q);
                    z_s_d = a_s_q;
                end else begin
                    sum_d = sum_t'(b_m_q - a_m_q);
                    z_s_d = b_s_q;
                end
                state_d = ADD_1;
            end
            ADD_1: begin
                if (sum_q == '0) begin
                    z_d     = '0;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else if (sum_q[DP_W]) begin
                    z_m_d    = sum_q[DP_W:4];
                    guard_d  = sum_q[3];
                    round_d  = sum_q[2];
                    sticky_d = sum_q[1] | sum_q[0];
                    z_e_d    = z_e_q + EXP_ONE;
                    state_d  = NORM_1;
                end else begin
                    z_m_d    = sum_q[DP_W-1:3];
                    guard_d  = sum_q[2];
                    round_d  = sum_q[1];
                    sticky_d = sum_q[0];
                    state_d  = NORM_1;
                end
            end
            NORM_1: begin
                if (!z_m_q[MAN_W-1] && (z_e_q > EXP_MIN)) begin
                    z_e_d   = z_e_q - EXP_ONE;
                    z_m_d   = {z_m_q[MAN_W-2:0], guard_q};
                    guard_d = round_q;
                    round_d = 1'b0;
                end else begin
                    state_d = NORM_2;
                end
            end
            NORM_2: begin
                if (z_e_q < EXP_MIN) begin
                    z_e_d    = z_e_q + EXP_ONE;
                    z_m_d    = {1'b0, z_m_q[MAN_W-1:1]};
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + man_t'(1);
                    if (z_m_q == '1) begin
                        z_e_d = z_e_q + EXP_ONE;
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                if (z_e_q > EXP_MAX) begin
                    z_d = POS_INF | {z_s_q, 31'h0};
                end else if ((z_e_q == EXP_MIN) && !z_m_q[MAN_W-1]) begin
                    z_d = {z_s_q, 8'h00, z_m_q[MAN_W-2:0]};
                end else begin
                    z_d = {z_s_q, 8'(z_e_q + EXP_BIAS), z_m_q[MAN_W-2:0]};
                end
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

endmodule

// File: rtl/fp32_add_unit.sv
// One-request-at-a-time pulse interface around the strobe/ack FP32 add core.
module fp32_add_unit
    import fp32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            ready_in,
    output logic [FP_W-1:0] out,
    output logic            ready_out
);

    wrap_state_e     state_q, state_d;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic            a_stb_q, a_stb_d, b_stb_q, b_stb_d;
    logic            z_ack_q, z_ack_d, ready_out_q, ready_out_d;

    logic            core_a_ack, core_b_ack, core_z_stb;
    logic [FP_W-1:0] core_z;

    fp32_add_core u_core (
        .clk          (clk),
        .rst          (rst),
        .input_a      (a_q),
        .input_b      (b_q),
        .input_a_stb  (a_stb_q),
        .input_b_stb  (b_stb_q),
        .input_a_ack  (core_a_ack),
        .input_b_ack  (core_b_ack),
        .output_z     (core_z),
        .output_z_stb (core_z_stb),
        .output_z_ack (z_ack_q)
    );

    assign out       = out_q;
    assign ready_out = ready_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            ready_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            ready_out_q <= ready_out_d;
        end
    end

    // Requests arriving outside IDLE are dropped, not queued.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = 1'b0;
        ready_out_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ready_in) begin
                    a_d     = a;
                    b_d     = b;
                    a_stb_d = 1'b1;
                    b_stb_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (a_stb_q && core_a_ack) begin
                    a_stb_d = 1'b0;
                end
                if (b_stb_q && core_b_ack) begin
                    b_stb_d = 1'b0;
                end
                if (core_z_stb) begin
                    out_d       = core_z;
                    ready_out_d = 1'b1;
                    z_ack_d     = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp32_add_unit.sv
// Scoreboard bench for fp32_add_unit: known vectors, specials, busy drop and mid-op reset.
module tb_fp32_add_unit;

    localparam int MAX_LATENCY = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        ready_in;
    logic [31:0] out;
    logic        ready_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic        prev_ro  = 1'b0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    fp32_add_unit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_in),
        .b         (b_in),
        .ready_in  (ready_in),
        .out       (out),
        .ready_out (ready_out)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every ready_out pulse.
    always @(negedge clk) begin
        if (!rst && ready_out) begin
            string       t;
            logic [31:0] e;
            done_cnt++;
            if (prev_ro) chk("ready_out_one_cycle", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready_out", 32'd1, 32'd0);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                chk(t, out, e);
            end
        end
        prev_ro = ready_out;
    end

    task automatic wait_done(input string tag, input int start);
        int cyc;
        cyc = 0;
        while (done_cnt == start && cyc < MAX_LATENCY + 4) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == start) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(tag_q.pop_back());
            end
        end else begin
            chk({tag, "_latency"}, 32'(((cyc - 1) >= 4) && ((cyc - 1) <= MAX_LATENCY)), 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_z);
        int start;
        @(negedge clk);
        a_in     = op_a;
        b_in     = op_b;
        ready_in = 1'b1;
        exp_q.push_back(exp_z);
        tag_q.push_back(tag);
        start = done_cnt;
        @(negedge clk);
        ready_in = 1'b0;
        wait_done(tag, start);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst      = 1'b1;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", out, 32'h0);
        chk("reset_ready_out", 32'(ready_out), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op("add_1p23_4p56",  32'h3F9D70A4, 32'h4091EB85, 32'h40B947AE);
        run_op("add_pos_pos",    32'h44F6AF68, 32'h4610099B, 32'h462EDF88);
        run_op("add_mixed_sign", 32'h473FF936, 32'hC6DDE29C, 32'h46A20FD0);
        run_op("exact_cancel",   32'h3F800000, 32'hBF800000, 32'h00000000);
        run_op("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run_op("overflow_inf",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_op("denorm_denorm",  32'h00000001, 32'h00000001, 32'h00000002);
        run_op("nan_operand",    32'h7F800001, 32'h3F800000, 32'h7FC00000);
        run_op("neg_inf_single", 32'hFF800000, 32'h3F800000, 32'hFF800000);
        run_op("neg0_neg0",      32'h80000000, 32'h80000000, 32'h80000000);
        run_op("neg0_pos0",      32'h80000000, 32'h00000000, 32'h00000000);
        run_op("zero_plus_x",    32'h00000000, 32'hC0490FDB, 32'hC0490FDB);
        run_op("one_plus_one",   32'h3F800000, 32'h3F800000, 32'h40000000);
        run_op("tie_to_even",    32'h3F800000, 32'h33800000, 32'h3F800000);
        run_op("above_half_ulp", 32'h3F800000, 32'h33800001, 32'h3F800001);
        run_op("deep_cancel",    32'h3F800000, 32'hBF7FFFFF, 32'h33800000);
        run_op("far_align_add",  32'h7F000000, 32'h3F800000, 32'h7F000000);
        run_op("far_align_rnd",  32'h7F000000, 32'hBF800000, 32'h7F000000);
        run_op("to_denormal",    32'h00800000, 32'h80000001, 32'h007FFFFF);

        // Second request while busy must be ignored.
        @(negedge clk);
        a_in     = 32'h3F800000;
        b_in     = 32'h40000000;
        ready_in = 1'b1;
        exp_q.push_back(32'h40400000);
        tag_q.push_back("busy_first");
        start = done_cnt;
        @(negedge clk);
        ready_in = 1'b0;
        repeat (2) @(negedge clk);
        a_in     = 32'h40A00000;
        b_in     = 32'h40A00000;
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        wait_done("busy_first", start);
        repeat (MAX_LATENCY + 10) @(negedge clk);
        chk("busy_single_pulse", 32'(done_cnt - start), 32'd1);
        chk("out_hold", out, 32'h40400000);

        // Reset mid-operation aborts with no completion.
        @(negedge clk);
        a_in     = 32'h3F9D70A4;
        b_in     = 32'h4091EB85;
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midop_rst_out", out, 32'h0);
        chk("midop_rst_ready_out", 32'(ready_out), 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = done_cnt;
        repeat (MAX_LATENCY + 10) @(negedge clk);
        chk("no_ready_after_rst", 32'(done_cnt - start), 32'd0);

        run_op("after_reset", 32'h473FF936, 32'hC6DDE29C, 32'h46A20FD0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
